// File: rtl/painter_pkg.sv
// Framebuffer / sprite-sheet geometry and the painter FSM state type.
package painter_pkg;
  localparam int FB_WIDTH     = 1280;
  localparam int FB_HEIGHT    = 300;
  localparam int SHEET_WIDTH  = 2446;
  localparam int SHEET_HEIGHT = 136;
  localparam int ROM_AW       = 19;
  localparam int FB_AW        = 19;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_CLEAR,
    ST_SETUP,
    ST_DRAW,
    ST_DRAIN,
    ST_DONE
  } painter_state_t;
endpackage

// File: rtl/runner_pkg.sv
// Shared slot types produced by the game-logic stage and consumed by the painter.
package runner_pkg;
  localparam int RENDER_SLOTS = 32;
  localparam int SLOT_W       = $clog2(RENDER_SLOTS);

  // Sheet rectangle of one sprite, unsigned sheet coordinates.
  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] w;
    logic [11:0] h;
  } sprite_t;

  // Screen position of one sprite, signed so sprites may hang off any edge.
  typedef struct packed {
    logic signed [11:0] x;
    logic signed [11:0] y;
  } pos_t;
endpackage

// File: rtl/blit_addr_gen.sv
// Per-sprite pixel walker: S0 source/destination address and clip, S1-aligned fb address.
module blit_addr_gen
  import runner_pkg::*, painter_pkg::*;
#(
  parameter int FB_W = FB_WIDTH,
  parameter int FB_H = FB_HEIGHT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              step,
  input  sprite_t           spr,
  input  pos_t              ps,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              last_pix,
  output logic [FB_AW-1:0]  fb_addr_s1,
  output logic              clip_s1
);
  logic [11:0]        col_reg, row_reg;
  logic [12:0]        sx, sy;
  logic signed [13:0] dx, dy;
  logic               clip;
  logic [FB_AW-1:0]   fb_addr_s0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (init) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (step) begin
      if (col_reg == spr.w - 12'd1) begin
        col_reg <= '0;
        row_reg <= row_reg + 12'd1;
      end else begin
        col_reg <= col_reg + 12'd1;
      end
    end
  end

  assign last_pix = (col_reg == spr.w - 12'd1) && (row_reg == spr.h - 12'd1);

  assign sx       = 13'(spr.x) + 13'(col_reg);
  assign sy       = 13'(spr.y) + 13'(row_reg);
  assign rom_addr = ROM_AW'(sy) * ROM_AW'(SHEET_WIDTH) + ROM_AW'(sx);

  // 14 bits so that a far-right position plus a wide sprite cannot wrap back on screen.
  assign dx = $signed({{2{ps.x[11]}}, ps.x}) + $signed({2'b00, col_reg});
  assign dy = $signed({{2{ps.y[11]}}, ps.y}) + $signed({2'b00, row_reg});

  assign clip = !dx[13] && (dx[12:0] < 13'(FB_W)) &&
                !dy[13] && (dy[12:0] < 13'(FB_H));

  assign fb_addr_s0 = FB_AW'(dy[12:0]) * FB_AW'(FB_W) + FB_AW'(dx[12:0]);

  // Delay destination by one cycle to meet rom_data from the registered ROM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_addr_s1 <= '0;
      clip_s1    <= 1'b0;
    end else begin
      fb_addr_s1 <= fb_addr_s0;
      clip_s1    <= step && clip;
    end
  end
endmodule

// File: rtl/sprite_painter.sv
// Rasterises the latched sprite slots into the back buffer, then swaps buffers.
module sprite_painter
  import runner_pkg::*, painter_pkg::*;
#(
  parameter int FB_W = FB_WIDTH,
  parameter int FB_H = FB_HEIGHT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  sprite_t           sprite [RENDER_SLOTS],
  input  pos_t              pos    [RENDER_SLOTS],
  output logic [ROM_AW-1:0] rom_addr,
  input  logic              rom_data,
  output logic [FB_AW-1:0]  fb_addr,
  output logic              fb_data,
  output logic              fb_we,
  output logic              fb_back_sel,
  output logic              painter_finished,
  output logic              frame_overrun
);
  localparam logic [FB_AW-1:0] CLEAR_LAST = FB_AW'(FB_W * FB_H - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(RENDER_SLOTS - 1);

  painter_state_t    state_reg, state_next;
  sprite_t           spr_lat_reg [RENDER_SLOTS];
  pos_t              pos_lat_reg [RENDER_SLOTS];
  logic [SLOT_W-1:0] slot_reg;
  logic [FB_AW-1:0]  clear_cnt_reg;
  logic              sel_reg, finished_reg, overrun_reg;

  sprite_t          cur_spr;
  pos_t             cur_pos;
  logic             skip, last_slot, last_pix, clip_s1;
  logic             ag_init, ag_step;
  logic [FB_AW-1:0] fb_addr_s1;

  genvar gi;
  generate
    for (gi = 0; gi < RENDER_SLOTS; gi++) begin : g_latch
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          spr_lat_reg[gi] <= '0;
          pos_lat_reg[gi] <= '0;
        end else if (state_reg == ST_LATCH) begin
          spr_lat_reg[gi] <= sprite[gi];
          pos_lat_reg[gi] <= pos[gi];
        end
      end
    end
  endgenerate

  assign cur_spr   = spr_lat_reg[slot_reg];
  assign cur_pos   = pos_lat_reg[slot_reg];
  assign skip      = (cur_spr.w == '0) || (cur_spr.h == '0);
  assign last_slot = (slot_reg == SLOT_LAST);
  assign ag_init   = (state_reg == ST_SETUP);
  assign ag_step   = (state_reg == ST_DRAW);

  blit_addr_gen #(
    .FB_W(FB_W),
    .FB_H(FB_H)
  ) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .init      (ag_init),
    .step      (ag_step),
    .spr       (cur_spr),
    .ps        (cur_pos),
    .rom_addr  (rom_addr),
    .last_pix  (last_pix),
    .fb_addr_s1(fb_addr_s1),
    .clip_s1   (clip_s1)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (frame_start) state_next = ST_LATCH;
      ST_LATCH: state_next = ST_CLEAR;
      ST_CLEAR: if (clear_cnt_reg == CLEAR_LAST) state_next = ST_SETUP;
      ST_SETUP: begin
        if (!skip)          state_next = ST_DRAW;
        else if (last_slot) state_next = ST_DONE;
      end
      ST_DRAW:  if (last_pix) state_next = ST_DRAIN;
      ST_DRAIN: state_next = last_slot ? ST_DONE : ST_SETUP;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clear_cnt_reg <= '0;
      slot_reg      <= '0;
      sel_reg       <= 1'b0;
      finished_reg  <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      overrun_reg <= frame_start && (state_reg != ST_IDLE);
      case (state_reg)
        ST_IDLE:  if (frame_start) finished_reg <= 1'b0;
        ST_LATCH: begin
          clear_cnt_reg <= '0;
          slot_reg      <= '0;
        end
        ST_CLEAR: clear_cnt_reg <= clear_cnt_reg + 1'b1;
        ST_SETUP: if (skip && !last_slot) slot_reg <= slot_reg + 1'b1;
        ST_DRAIN: if (!last_slot) slot_reg <= slot_reg + 1'b1;
        ST_DONE: begin
          sel_reg      <= ~sel_reg;
          finished_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Clear and draw never overlap, so the write port is a simple state mux.
  assign fb_we            = (state_reg == ST_CLEAR) || (clip_s1 && rom_data);
  assign fb_data          = (state_reg != ST_CLEAR) && clip_s1 && rom_data;
  assign fb_addr          = (state_reg == ST_CLEAR) ? clear_cnt_reg : fb_addr_s1;
  assign fb_back_sel      = sel_reg;
  assign painter_finished = finished_reg;
  assign frame_overrun    = overrun_reg;
endmodule

// File: tb/tb_sprite_painter.sv
// Scoreboard bench for sprite_painter on a reduced-height framebuffer.
module tb_sprite_painter;
  import runner_pkg::*;
  import painter_pkg::*;

  localparam int TB_H = 8;
  localparam int CLR  = FB_WIDTH * TB_H;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  sprite_t     spr_in [RENDER_SLOTS];
  pos_t        pos_in [RENDER_SLOTS];
  logic [18:0] rom_addr, fb_addr;
  logic        rom_data = 1'b0;
  logic        fb_data, fb_we, fb_back_sel, painter_finished, frame_overrun;

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int clear_idx = 0;
  int clear_bad = 0;
  int overrun_cnt = 0;
  int rom_mode = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  sprite_painter #(.FB_H(TB_H)) dut (
    .clk             (clk),
    .rst             (rst),
    .frame_start     (frame_start),
    .sprite          (spr_in),
    .pos             (pos_in),
    .rom_addr        (rom_addr),
    .rom_data        (rom_data),
    .fb_addr         (fb_addr),
    .fb_data         (fb_data),
    .fb_we           (fb_we),
    .fb_back_sel     (fb_back_sel),
    .painter_finished(painter_finished),
    .frame_overrun   (frame_overrun)
  );

  function automatic logic rom_pix(input int a, input int mode);
    if (mode == 0) return 1'b1;
    return (((a % SHEET_WIDTH) + (a / SHEET_WIDTH)) % 2) == 0;
  endfunction

  always @(posedge clk) rom_data <= rom_pix(int'(rom_addr), rom_mode);

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (frame_overrun) overrun_cnt++;
      if (fb_we) begin
        if (!fb_data) begin
          if (int'(fb_addr) != clear_idx) clear_bad++;
          clear_idx++;
        end else if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=%0d required=none", fb_addr);
        end else begin
          int e;
          e = exp_q.pop_front();
          check("ink_addr", int'(fb_addr), e);
        end
      end
    end
  end

  task automatic clear_slots();
    for (int i = 0; i < RENDER_SLOTS; i++) begin
      spr_in[i] = '0;
      pos_in[i] = '0;
    end
  endtask

  task automatic run_pass(input int exp_cycles, input int overrun_at,
                          input int scramble, input int exp_sel);
    int cycles;
    clear_idx   = 0;
    clear_bad   = 0;
    overrun_cnt = 0;
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    check("finished_cleared", int'(painter_finished), 0);
    cycles = 0;
    while (!painter_finished && cycles < exp_cycles + 50) begin
      @(posedge clk);
      cycles++;
      #1;
      frame_start = (cycles == overrun_at);
      if (scramble != 0 && cycles == 2) begin
        spr_in[0] = '0;
        pos_in[0] = '0;
      end
    end
    frame_start = 1'b0;
    check("pass_cycles", cycles, exp_cycles);
    check("finished_set", int'(painter_finished), 1);
    check("back_sel", int'(fb_back_sel), exp_sel);
    check("clear_writes", clear_idx, CLR);
    check("clear_order", clear_bad, 0);
    check("missing_writes", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
    check("finished_held", int'(painter_finished), 1);
    check("sel_held", int'(fb_back_sel), exp_sel);
    check("overrun_pulses", overrun_cnt, (overrun_at > 0) ? 1 : 0);
  endtask

  initial begin
    int cycles;
    int wr;
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    int wr;
    clear_slots();
    repeat (3) @(posedge clk);
    #1;
    check("rst_fb_we", int'(fb_we), 0);
    check("rst_fb_data", int'(fb_data), 0);
    check("rst_fb_addr", int'(fb_addr), 0);
    check("rst_rom_addr", int'(rom_addr), 0);
    check("rst_sel", int'(fb_back_sel), 0);
    check("rst_finished", int'(painter_finished), 0);
    check("rst_overrun", int'(frame_overrun), 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // All slots empty: clear, 32 one-cycle skips, swap.
    run_pass(CLR + 34, 0, 0, 1);

    // 4x2 fully inked sprite at (10,5); inputs changed after the latch must not matter.
    spr_in[0] = '{x: 12'd0, y: 12'd0, w: 12'd4, h: 12'd2};
    pos_in[0] = '{x: 12'd10, y: 12'd5};
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++)
        exp_q.push_back((5 + r) * FB_WIDTH + 10 + c);
    run_pass(CLR + 43, 0, 1, 0);

    // Same sprite hanging off the left and bottom edges.
    spr_in[0] = '{x: 12'd0, y: 12'd0, w: 12'd4, h: 12'd2};
    pos_in[0] = '{x: 12'hFFE, y: 12'(TB_H - 1)};
    exp_q.push_back((TB_H - 1) * FB_WIDTH + 0);
    exp_q.push_back((TB_H - 1) * FB_WIDTH + 1);
    run_pass(CLR + 43, 0, 0, 1);

    // Checkerboard sheet, 2x2 sprite from sheet x=1: ink at (1,0) and (0,1) of the sprite.
    rom_mode = 1;
    spr_in[0] = '{x: 12'd1, y: 12'd0, w: 12'd2, h: 12'd2};
    pos_in[0] = '{x: 12'd10, y: 12'd5};
    exp_q.push_back(5 * FB_WIDTH + 11);
    exp_q.push_back(6 * FB_WIDTH + 10);
    run_pass(CLR + 39, 0, 0, 0);

    // Reset during the draw of slot 3.
    rom_mode = 0;
    mon_en = 1'b0;
    clear_slots();
    spr_in[3] = '{x: 12'd0, y: 12'd0, w: 12'd100, h: 12'd10};
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    cycles = 0;
    while (!(fb_we && fb_data) && cycles < CLR + 200) begin
      @(posedge clk);
      cycles++;
      #1;
    end
    check("reach_draw", int'(fb_we && fb_data), 1);
    rst = 1'b1;
    #1;
    check("abort_fb_we", int'(fb_we), 0);
    check("abort_finished", int'(painter_finished), 0);
    check("abort_sel", int'(fb_back_sel), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    wr = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (fb_we) wr++;
    end
    check("idle_after_rst", wr, 0);
    check("finished_after_rst", int'(painter_finished), 0);

    // frame_start during CLEAR is flagged and otherwise ignored.
    clear_slots();
    mon_en = 1'b1;
    run_pass(CLR + 34, 100, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
